prog_imem_responder: RTL and testbench

- Instruction-memory responder for the fetch stage. It takes the word address derived from the fetch unit's PC output and returns the 32-bit instruction that the fetch unit consumes.
- It also contains a byte-serial program loader (fed by the UART receiver) that rewrites the memory in place. While loading, it holds the CPU in stall.
- It sits between the fetch unit, the UART byte receiver and the top-level reset logic.

---
 rtl/prog_imem_responder_if.sv | 44 ++++
 rtl/prog_imem_responder.sv | 144 ++++++++++++++
 tb/tb_prog_imem_responder.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/prog_imem_responder_if.sv
`default_nettype none
// ============================================================================
// Module  : prog_imem_responder_if
// Brief   : Fetch-side and loader-side signals of the instruction memory.
// Revision: 1.0  initial release
// ============================================================================
interface prog_imem_responder_if #(
    parameter int ADDR_W = 14
) ();
    logic [ADDR_W-1:0] fetch_addr;
    logic [31:0]       Instruction;
    logic              upg_en;
    logic              upg_byte_valid;
    logic [7:0]        upg_byte;
    logic              upg_last;
    logic              cpu_stall;
    logic              upg_done;
    logic              upg_overflow;

    modport master (
        output fetch_addr,
        output upg_en,
        output upg_byte_valid,
        output upg_byte,
        output upg_last,
        input  Instruction,
        input  cpu_stall,
        input  upg_done,
        input  upg_overflow
    );

    modport slave (
        input  fetch_addr,
        input  upg_en,
        input  upg_byte_valid,
        input  upg_byte,
        input  upg_last,
        output Instruction,
        output cpu_stall,
        output upg_done,
        output upg_overflow
    );
endinterface
`default_nettype wire

// File: rtl/prog_imem_responder.sv
`default_nettype none
// ============================================================================
// Module  : prog_imem_responder
// Brief   : Instruction memory with registered fetch and byte-serial loader.
// Revision: 1.0  initial release
// ============================================================================
module prog_imem_responder #(
    parameter int          ADDR_W   = 14,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  wire logic              clock,
    input  wire logic              reset,
    prog_imem_responder_if.slave   bus
);
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_LOAD  = 2'd1;
    localparam logic [1:0] c_WRITE = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    localparam int                c_DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = {ADDR_W{1'b1}};

    logic [1:0]        r_state;
    logic              r_en_d;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [1:0]        r_byte_cnt;
    logic [31:0]       r_word;
    logic              r_word_last;
    logic              r_full;
    logic              r_overflow;
    logic [31:0]       r_instr;
    logic [31:0]       r_mem [c_DEPTH];

    logic              w_en_rise;
    logic              w_mem_we;
    logic [31:0]       w_word_next;

    assign w_en_rise = bus.upg_en & ~r_en_d;
    assign w_mem_we  = (r_state == c_WRITE) & ~reset;

    always_comb begin
        w_word_next = r_word;
        w_word_next[{r_byte_cnt, 3'b000} +: 8] = bus.upg_byte;
    end

    // Edge detector tracks upg_en even in reset so a level held across reset
    // does not start a spurious load session.
    always_ff @(posedge clock) begin
        r_en_d <= bus.upg_en;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_wr_ptr    <= '0;
            r_byte_cnt  <= 2'd0;
            r_word      <= 32'h0;
            r_word_last <= 1'b0;
            r_full      <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_en_rise) begin
                        r_state     <= c_LOAD;
                        r_wr_ptr    <= '0;
                        r_byte_cnt  <= 2'd0;
                        r_word      <= 32'h0;
                        r_word_last <= 1'b0;
                        r_full      <= 1'b0;
                        r_overflow  <= 1'b0;
                    end
                end
                c_LOAD: begin
                    if (!bus.upg_en) begin
                        r_state <= c_IDLE;
                    end else if (bus.upg_byte_valid) begin
                        if (r_full) begin
                            // Memory already holds its last word: discard.
                            r_overflow <= 1'b1;
                            if (bus.upg_last) begin
                                r_state <= c_DONE;
                            end
                        end else begin
                            r_word      <= w_word_next;
                            r_byte_cnt  <= r_byte_cnt + 2'd1;
                            r_word_last <= bus.upg_last;
                            if ((r_byte_cnt == 2'd3) || bus.upg_last) begin
                                r_state <= c_WRITE;
                            end
                        end
                    end
                end
                c_WRITE: begin
                    r_byte_cnt  <= 2'd0;
                    r_word      <= 32'h0;
                    r_word_last <= 1'b0;
                    if (r_wr_ptr == c_LAST_ADDR) begin
                        r_full <= 1'b1;
                    end else begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                    end
                    if (!bus.upg_en) begin
                        r_state <= c_IDLE;
                    end else if (r_word_last) begin
                        r_state <= c_DONE;
                    end else begin
                        r_state <= c_LOAD;
                    end
                end
                c_DONE: begin
                    if (!bus.upg_en) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_mem_we) begin
            r_mem[r_wr_ptr] <= r_word;
        end
    end

    // Reads only happen outside a load, so the port never sees a collision.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_instr <= NOP_WORD;
        end else if ((r_state == c_IDLE) || (r_state == c_DONE)) begin
            r_instr <= r_mem[bus.fetch_addr];
        end else begin
            r_instr <= NOP_WORD;
        end
    end

    assign bus.Instruction  = r_instr;
    assign bus.cpu_stall    = (r_state == c_LOAD) || (r_state == c_WRITE);
    assign bus.upg_done     = (r_state == c_DONE);
    assign bus.upg_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_prog_imem_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_prog_imem_responder
// Brief   : Directed, table-driven bench for prog_imem_responder.
// Revision: 1.0  initial release
// ============================================================================
module tb_prog_imem_responder;
    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    prog_imem_responder_if #(.ADDR_W(14)) m_if ();
    prog_imem_responder_if #(.ADDR_W(2))  s_if ();

    prog_imem_responder #(.ADDR_W(14), .NOP_WORD(32'h0000_0000)) dut_m (
        .clock (clock),
        .reset (reset),
        .bus   (m_if.slave)
    );

    prog_imem_responder #(.ADDR_W(2), .NOP_WORD(32'h0000_0000)) dut_s (
        .clock (clock),
        .reset (reset),
        .bus   (s_if.slave)
    );

    typedef struct {
        logic [13:0] addr;
        logic [31:0] exp;
    } vec_t;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One byte strobe followed by a quiet cycle, so WRITE never sees a strobe.
    task automatic send(input bit sel, input logic [7:0] b, input bit last);
        if (!sel) begin
            m_if.upg_byte_valid = 1'b1; m_if.upg_byte = b; m_if.upg_last = last;
        end else begin
            s_if.upg_byte_valid = 1'b1; s_if.upg_byte = b; s_if.upg_last = last;
        end
        tick();
        m_if.upg_byte_valid = 1'b0; m_if.upg_last = 1'b0;
        s_if.upg_byte_valid = 1'b0; s_if.upg_last = 1'b0;
        tick();
    endtask

    task automatic fetch(input bit sel, input vec_t v, input string name);
        if (!sel) begin
            m_if.fetch_addr = v.addr;
            tick();
            check(name, m_if.Instruction, v.exp);
        end else begin
            s_if.fetch_addr = v.addr[1:0];
            tick();
            check(name, s_if.Instruction, v.exp);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        v_pre [6];
        vec_t        v_main[4];
        vec_t        v_small[4];
        logic [31:0] pre_words[6];
        logic [31:0] w;
        logic [7:0]  main_bytes[6];

        for (int i = 0; i < 5; i++) pre_words[i] = 32'h1111_0000 + 32'(i);
        pre_words[5] = 32'h2008_0001;
        for (int i = 0; i < 6; i++) begin
            v_pre[i].addr = 14'(i);
            v_pre[i].exp  = pre_words[i];
        end
        v_main[0] = '{14'd0, 32'h2008_0001};
        v_main[1] = '{14'd1, 32'h0000_EEFF};
        v_main[2] = '{14'd2, 32'h1111_0002};
        v_main[3] = '{14'd5, 32'h2008_0001};
        v_small[0] = '{14'd0, 32'h0403_0201};
        v_small[1] = '{14'd1, 32'h0807_0605};
        v_small[2] = '{14'd2, 32'h0C0B_0A09};
        v_small[3] = '{14'd3, 32'h100F_0E0D};
        main_bytes = '{8'h01, 8'h00, 8'h08, 8'h20, 8'hFF, 8'hEE};

        reset = 1'b1;
        m_if.fetch_addr = '0; m_if.upg_en = 1'b0; m_if.upg_byte_valid = 1'b0;
        m_if.upg_byte = 8'h00; m_if.upg_last = 1'b0;
        s_if.fetch_addr = '0; s_if.upg_en = 1'b0; s_if.upg_byte_valid = 1'b0;
        s_if.upg_byte = 8'h00; s_if.upg_last = 1'b0;
        repeat (3) tick();

        // Reset state
        check("reset_instr", m_if.Instruction, 32'h0);
        check("reset_stall", {31'b0, m_if.cpu_stall}, 32'd0);
        check("reset_done",  {31'b0, m_if.upg_done}, 32'd0);
        check("reset_ovf",   {31'b0, m_if.upg_overflow}, 32'd0);
        reset = 1'b0;
        tick();

        // Preload six words, mem[5] = 2008_0001
        m_if.upg_en = 1'b1;
        tick();
        check("pre_stall_start", {31'b0, m_if.cpu_stall}, 32'd1);
        for (int wi = 0; wi < 6; wi++) begin
            w = pre_words[wi];
            for (int b = 0; b < 4; b++) send(1'b0, w[8*b +: 8], (wi == 5) && (b == 3));
            if (wi == 2) begin
                check("pre_instr_nop", m_if.Instruction, 32'h0);
                check("pre_stall_mid", {31'b0, m_if.cpu_stall}, 32'd1);
            end
        end
        check("pre_done", {31'b0, m_if.upg_done}, 32'd1);
        check("pre_stall_end", {31'b0, m_if.cpu_stall}, 32'd0);
        m_if.upg_en = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) fetch(1'b0, v_pre[i], $sformatf("pre_fetch%0d", i));

        // Main load: 01,00,08,20,FF,EE(last)
        m_if.upg_en = 1'b1;
        tick();
        check("load_stall_start", {31'b0, m_if.cpu_stall}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            send(1'b0, main_bytes[i], i == 5);
            if (i == 2) check("load_instr_nop", m_if.Instruction, 32'h0);
        end
        check("load_done", {31'b0, m_if.upg_done}, 32'd1);
        check("load_stall_end", {31'b0, m_if.cpu_stall}, 32'd0);
        m_if.fetch_addr = 14'd1;
        m_if.upg_en = 1'b0;
        tick();
        check("done_cleared", {31'b0, m_if.upg_done}, 32'd0);
        check("done_fetch1", m_if.Instruction, 32'h0000_EEFF);
        for (int i = 0; i < 4; i++) fetch(1'b0, v_main[i], $sformatf("main_fetch%0d", i));

        // Abort after two bytes: nothing written
        m_if.upg_en = 1'b1;
        tick();
        send(1'b0, 8'hAA, 1'b0);
        send(1'b0, 8'hBB, 1'b0);
        m_if.upg_en = 1'b0;
        tick();
        check("abort_stall", {31'b0, m_if.cpu_stall}, 32'd0);
        check("abort_done",  {31'b0, m_if.upg_done}, 32'd0);
        fetch(1'b0, '{14'd0, 32'h2008_0001}, "abort_mem0");

        // Abort while WRITE is pending: the write still lands
        m_if.upg_en = 1'b1;
        tick();
        send(1'b0, 8'h44, 1'b0);
        send(1'b0, 8'h33, 1'b0);
        send(1'b0, 8'h22, 1'b0);
        m_if.upg_byte_valid = 1'b1; m_if.upg_byte = 8'h11;
        tick();
        m_if.upg_byte_valid = 1'b0;
        m_if.upg_en = 1'b0;
        tick();
        check("abortw_stall", {31'b0, m_if.cpu_stall}, 32'd0);
        check("abortw_done",  {31'b0, m_if.upg_done}, 32'd0);
        fetch(1'b0, '{14'd0, 32'h1122_3344}, "abortw_mem0");

        // Reset after six bytes: mem[0] written, mem[1] untouched
        m_if.upg_en = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) send(1'b0, 8'(i + 1), 1'b0);
        check("rst_mid_stall_before", {31'b0, m_if.cpu_stall}, 32'd1);
        reset = 1'b1;
        m_if.upg_en = 1'b0;
        tick();
        check("rst_mid_instr", m_if.Instruction, 32'h0);
        check("rst_mid_stall", {31'b0, m_if.cpu_stall}, 32'd0);
        check("rst_mid_done",  {31'b0, m_if.upg_done}, 32'd0);
        check("rst_mid_ovf",   {31'b0, m_if.upg_overflow}, 32'd0);
        reset = 1'b0;
        fetch(1'b0, '{14'd0, 32'h0403_0201}, "rst_mid_mem0");
        fetch(1'b0, '{14'd1, 32'h0000_EEFF}, "rst_mid_mem1");

        // ADDR_W=2: 20 bytes into a 4-word memory
        s_if.upg_en = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) send(1'b1, 8'(i + 1), i == 19);
        check("ovf_flag",  {31'b0, s_if.upg_overflow}, 32'd1);
        check("ovf_done",  {31'b0, s_if.upg_done}, 32'd1);
        check("ovf_stall", {31'b0, s_if.cpu_stall}, 32'd0);
        check("ovf_wr_ptr", {30'b0, dut_s.r_wr_ptr}, 32'd3);
        s_if.upg_en = 1'b0;
        tick();
        check("ovf_sticky", {31'b0, s_if.upg_overflow}, 32'd1);
        for (int i = 0; i < 4; i++) fetch(1'b1, v_small[i], $sformatf("small_fetch%0d", i));
        s_if.upg_en = 1'b1;
        tick();
        check("ovf_cleared_on_load", {31'b0, s_if.upg_overflow}, 32'd0);
        s_if.upg_en = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
